// File: rtl/seg2hex_capture.sv
// seg2hex_capture
// Snoops a multiplexed, active-low 7-segment display bus and rebuilds the
// displayed hex word for the debug/readback path. Inputs are synchronized
// through two flops and a pattern is committed to its digit only after
// STABLE identical samples have been seen.
//
// Optional build macro: SEG2HEX_DP_EN
//   When defined, seg is 8 bits wide (bit7 = decimal point, active-low),
//   the point takes part in the stability compare, and a dp output reports
//   the lit point of each committed digit.
//
// Ports:
//   clk     in   system clock, rising edge
//   clrn    in   asynchronous active-low reset
//   seg     in   segments, active-low, bit0=a .. bit6=g (bit7=dp when enabled)
//   an      in   digit enables, active-low, one-hot-low when valid
//   ack     in   clears dvalid, bad and frame on the next edge
//   hex     out  decoded nibbles, digit i at hex[4i+3:4i]
//   dvalid  out  digit committed since last ack/reset
//   blank   out  last commit of digit was an all-off pattern
//   bad     out  sticky: an illegal glyph was committed
//   frame   out  registered AND of dvalid
//   dp      out  (SEG2HEX_DP_EN only) decimal point of last commit
//
// State | Meaning
// IDLE  | no single digit selected, counter cleared
// TRACK | candidate latched, counting identical samples
// HOLD  | candidate committed, waiting for the bus to change
module seg2hex_capture #(
    parameter int DIGITS = 8,
    parameter int STABLE = 4
) (
    input  logic                  clk,
    input  logic                  clrn,
`ifdef SEG2HEX_DP_EN
    input  logic [7:0]            seg,
`else
    input  logic [6:0]            seg,
`endif
    input  logic [DIGITS-1:0]     an,
    input  logic                  ack,
    output logic [4*DIGITS-1:0]   hex,
    output logic [DIGITS-1:0]     dvalid,
    output logic [DIGITS-1:0]     blank,
`ifdef SEG2HEX_DP_EN
    output logic [DIGITS-1:0]     dp,
`endif
    output logic                  bad,
    output logic                  frame
);

`ifdef SEG2HEX_DP_EN
    localparam int SEG_W = 8;
`else
    localparam int SEG_W = 7;
`endif

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [SEG_W-1:0]    r_seg_m, r_seg_s, r_cand_seg;
    logic [DIGITS-1:0]   r_an_m, r_an_s, r_cand_an;
    logic [1:0]          r_state;
    logic [3:0]          r_cnt;
    logic [4*DIGITS-1:0] r_hex;
    logic [DIGITS-1:0]   r_dvalid, r_blank;
    logic                r_bad, r_frame;

    logic [DIGITS-1:0]   w_an_act;
    logic                w_sel, w_match, w_commit;
    logic [3:0]          w_cnt_inc;
    logic [3:0]          w_nib;
    logic                w_legal, w_blank;

    // Two-flop synchronizers; idle bus (all off) is all ones.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_seg_m <= '1;
            r_seg_s <= '1;
            r_an_m  <= '1;
            r_an_s  <= '1;
        end else begin
            r_seg_m <= seg;
            r_seg_s <= r_seg_m;
            r_an_m  <= an;
            r_an_s  <= r_an_m;
        end
    end

    // Exactly one enable low: x != 0 and x has a single set bit.
    assign w_an_act  = ~r_an_s;
    assign w_sel     = (w_an_act != '0) && ((w_an_act & (w_an_act - DIGITS'(1))) == '0);
    assign w_match   = (r_seg_s == r_cand_seg) && (r_an_s == r_cand_an);
    assign w_cnt_inc = r_cnt + 4'd1;
    assign w_commit  = (r_state == ST_TRACK) && w_sel && w_match && (w_cnt_inc == 4'(STABLE));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_cand_seg <= '1;
            r_cand_an  <= '1;
        end else if (!w_sel) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else if (r_state == ST_IDLE || !w_match) begin
            r_state    <= ST_TRACK;
            r_cnt      <= 4'd1;
            r_cand_seg <= r_seg_s;
            r_cand_an  <= r_an_s;
        end else if (r_state == ST_TRACK) begin
            r_cnt <= w_cnt_inc;
            if (w_commit)
                r_state <= ST_HOLD;
        end
    end

    // Glyph decode of the committed candidate (decimal point ignored).
    always_comb begin
        w_nib   = 4'h0;
        w_legal = 1'b1;
        w_blank = 1'b0;
        case (r_cand_seg[6:0])
            7'b1000000: w_nib = 4'h0;
            7'b1111001: w_nib = 4'h1;
            7'b0100100: w_nib = 4'h2;
            7'b0110000: w_nib = 4'h3;
            7'b0011001: w_nib = 4'h4;
            7'b0010010: w_nib = 4'h5;
            7'b0000010: w_nib = 4'h6;
            7'b1111000: w_nib = 4'h7;
            7'b0000000: w_nib = 4'h8;
            7'b0010000: w_nib = 4'h9;
            7'b0001000: w_nib = 4'hA;
            7'b0000011: w_nib = 4'hB;
            7'b1000110: w_nib = 4'hC;
            7'b0100001: w_nib = 4'hD;
            7'b0000110: w_nib = 4'hE;
            7'b0001110: w_nib = 4'hF;
            7'b1111111: begin
                w_legal = 1'b0;
                w_blank = 1'b1;
            end
            default:    w_legal = 1'b0;
        endcase
    end

    // ack clears first; a coincident commit then re-sets its own bits.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_hex    <= '0;
            r_dvalid <= '0;
            r_blank  <= '0;
            r_bad    <= 1'b0;
            r_frame  <= 1'b0;
        end else begin
            r_frame <= ack ? 1'b0 : &r_dvalid;
            if (ack) begin
                r_dvalid <= '0;
                r_bad    <= 1'b0;
            end
            if (w_commit) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (!r_cand_an[i]) begin
                        r_dvalid[i] <= 1'b1;
                        if (w_legal) begin
                            r_hex[4*i +: 4] <= w_nib;
                            r_blank[i]      <= 1'b0;
                        end else if (w_blank) begin
                            r_hex[4*i +: 4] <= 4'h0;
                            r_blank[i]      <= 1'b1;
                        end
                    end
                end
                if (!w_legal && !w_blank)
                    r_bad <= 1'b1;
            end
        end
    end

`ifdef SEG2HEX_DP_EN
    logic [DIGITS-1:0] r_dp;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_dp <= '0;
        end else if (w_commit) begin
            for (int i = 0; i < DIGITS; i++)
                if (!r_cand_an[i])
                    r_dp[i] <= ~r_cand_seg[7];
        end
    end

    assign dp = r_dp;
`endif

    assign hex    = r_hex;
    assign dvalid = r_dvalid;
    assign blank  = r_blank;
    assign bad    = r_bad;
    assign frame  = r_frame;

endmodule

// File: tb/tb_seg2hex_capture.sv
// tb_seg2hex_capture
// Directed bench for seg2hex_capture (default build, DIGITS=8, STABLE=4).
// Inputs change 1 ns after a rising edge; outputs are sampled at the same
// point, so "edge N" below counts rising edges after an input change.
module tb_seg2hex_capture;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic [6:0]  seg = 7'h7F;
    logic [7:0]  an = 8'hFF;
    logic        ack = 1'b0;
    logic [31:0] hex;
    logic [7:0]  dvalid, blank;
    logic        bad, frame;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] glyph [9];

    seg2hex_capture #(.DIGITS(8), .STABLE(4)) dut (
        .clk    (clk),
        .clrn   (clrn),
        .seg    (seg),
        .an     (an),
        .ack    (ack),
        .hex    (hex),
        .dvalid (dvalid),
        .blank  (blank),
        .bad    (bad),
        .frame  (frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        glyph[1] = 7'b1111001; glyph[2] = 7'b0100100; glyph[3] = 7'b0110000;
        glyph[4] = 7'b0011001; glyph[5] = 7'b0010010; glyph[6] = 7'b0000010;
        glyph[7] = 7'b1111000; glyph[8] = 7'b0000000; glyph[0] = 7'b1000000;

        // Reset state
        tick(2);
        check("rst_hex",    hex,    32'h0);
        check("rst_dvalid", {24'h0, dvalid}, 32'h0);
        check("rst_blank",  {24'h0, blank},  32'h0);
        check("rst_bad",    {31'h0, bad},    32'h0);
        check("rst_frame",  {31'h0, frame},  32'h0);
        clrn = 1'b1;
        tick(1);

        // Basic commit latency: digit 0 shows '3'
        an = 8'hFE; seg = 7'b0110000;
        tick(5);
        check("lat_early_dvalid", {24'h0, dvalid}, 32'h0);
        tick(1);
        check("lat_hex0",   {28'h0, hex[3:0]}, 32'h3);
        check("lat_dvalid", {24'h0, dvalid},   32'h1);
        check("lat_blank",  {24'h0, blank},    32'h0);
        check("lat_bad",    {31'h0, bad},      32'h0);

        // Debounce: digit 1 toggling 6/5 every 2 cycles never settles
        an = 8'hFD;
        for (int k = 0; k < 10; k++) begin
            seg = (k % 2 == 0) ? 7'b0000010 : 7'b0010010;
            tick(2);
        end
        check("deb_no_commit", {31'h0, dvalid[1]}, 32'h0);
        seg = 7'b0000010;
        tick(5);
        check("deb_hold_early", {31'h0, dvalid[1]}, 32'h0);
        tick(1);
        check("deb_hex1",   {28'h0, hex[7:4]}, 32'h6);
        check("deb_dvalid", {24'h0, dvalid},   32'h3);

        // Clear before the full scan
        ack = 1'b1; tick(1); ack = 1'b0;
        check("ack1_dvalid", {24'h0, dvalid}, 32'h0);

        // Full scan: digit d shows d+1
        for (int d = 0; d < 7; d++) begin
            an = ~(8'h01 << d); seg = glyph[d+1];
            tick(8);
        end
        an = 8'h7F; seg = glyph[8];
        tick(6);
        check("scan_dvalid",   {24'h0, dvalid}, 32'hFF);
        check("scan_frame_lo", {31'h0, frame},  32'h0);
        tick(1);
        check("scan_frame_hi", {31'h0, frame},  32'h1);
        check("scan_hex",      hex,             32'h87654321);
        tick(1);
        ack = 1'b1; tick(1); ack = 1'b0;
        check("ack2_dvalid", {24'h0, dvalid}, 32'h0);
        check("ack2_frame",  {31'h0, frame},  32'h0);
        check("ack2_hex",    hex,             32'h87654321);

        // Illegal pattern on digit 2
        an = 8'hFB; seg = 7'b1111110;
        tick(5);
        check("ill_bad_early", {31'h0, bad}, 32'h0);
        tick(1);
        check("ill_bad",    {31'h0, bad},       32'h1);
        check("ill_hex2",   {28'h0, hex[11:8]}, 32'h3);
        check("ill_dvalid", {24'h0, dvalid},    32'h04);
        tick(2);

        // Blank pattern on digit 3
        an = 8'hF7; seg = 7'b1111111;
        tick(6);
        check("blk_blank",  {24'h0, blank},      32'h08);
        check("blk_hex3",   {28'h0, hex[15:12]}, 32'h0);
        check("blk_dvalid", {24'h0, dvalid},     32'h0C);
        check("blk_bad",    {31'h0, bad},        32'h1);
        tick(2);

        // ack on the very edge digit 4 commits 'A'
        an = 8'hEF; seg = 7'b0001000;
        tick(5);
        ack = 1'b1; tick(1); ack = 1'b0;
        check("ackc_dvalid", {24'h0, dvalid},     32'h10);
        check("ackc_bad",    {31'h0, bad},        32'h0);
        check("ackc_hex4",   {28'h0, hex[19:16]}, 32'hA);
        tick(2);

        // Invalid enables: two digits, then none
        an = 8'hFC; seg = glyph[7];
        tick(30);
        an = 8'hFF; seg = glyph[0];
        tick(30);
        check("ben_dvalid", {24'h0, dvalid}, 32'h10);
        check("ben_hex",    hex,             32'h876A0321);
        check("ben_blank",  {24'h0, blank},  32'h08);

        // Reset mid-TRACK on digit 0
        an = 8'hFE; seg = 7'b0010000;
        tick(3);
        clrn = 1'b0;
        #2;
        check("mrst_hex",    hex,            32'h0);
        check("mrst_dvalid", {24'h0, dvalid}, 32'h0);
        clrn = 1'b1;
        tick(5);
        check("mrst_no_commit", {24'h0, dvalid}, 32'h0);
        tick(1);
        check("mrst_hex0",   {28'h0, hex[3:0]}, 32'h9);
        check("mrst_dvalid2", {24'h0, dvalid},  32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg2hex_capture.md
Name: seg2hex_capture

Overview:
- Receive-side counterpart of the hex-to-7-segment encoder. Snoops a multiplexed, active-low 7-segment display bus: segment lines plus active-low digit enables.
- Decodes each digit's segment pattern back to a 4-bit hex nibble and holds the reconstructed word for the debug/readback path.
- Synchronizes the inputs and debounces them. A value is committed only after it has been stable for a set time.
- Flags blank digits and any pattern that is not a legal hex glyph.

Parameters:
- DIGITS, 8, number of multiplexed digits (1..8).
- STABLE, 4, consecutive identical synchronized samples required before a commit (2..15).

Ports:
- clk  input  1  system clock, rising edge.
- clrn  input  1  asynchronous active-low reset.
- seg  input  7  observed segments, active-low, bit0=a .. bit6=g.
- an  input  DIGITS  observed digit enables, active-low, one-hot-low when valid.
- ack  input  1  clears dvalid, frame and bad on the next edge.
- hex  output  4*DIGITS  decoded nibbles; digit i occupies hex[4i+3:4i].
- dvalid  output  DIGITS  digit i committed since the last ack/reset.
- blank  output  DIGITS  last commit for digit i was pattern 1111111.
- bad  output  1  sticky: an illegal pattern was committed.
- frame  output  1  level: all dvalid bits set.

Behaviour:
- Reset (clrn=0, async): hex=0, dvalid=0, blank=0, bad=0, frame=0. Sync flops load 1s (idle, all off). Counter=0. FSM=IDLE.
- Sync: seg and an each pass through 2 flip-flops. All further logic uses the stage-2 values (s_seg, s_an).
- Decode table, segment pattern to nibble:
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3
  - 0011001=4, 0010010=5, 0000010=6, 1111000=7
  - 0000000=8, 0010000=9, 0001000=A, 0000011=b
  - 1000110=C, 0100001=d, 0000110=E, 0001110=F
  - 1111111 = blank.
  - Anything else = illegal.
- Selection: exactly one zero bit in s_an selects digit i. All-ones or more than one zero = no selection.
- FSM states:
  - IDLE: no selection, cnt=0. Go to TRACK when a selection appears (cnt=1, latch s_seg/s_an as candidate).
  - TRACK: on each edge where s_seg and s_an equal the candidate, cnt+1. On the edge where cnt reaches STABLE, commit and go to HOLD. Any mismatch with a valid selection: reload candidate, cnt=1, stay in TRACK. Selection lost: go to IDLE.
  - HOLD: committed. Stay while the sample equals the candidate; never re-commit. Mismatch with a valid selection: TRACK with cnt=1. Selection lost: IDLE.
- Commit to digit i, all in one edge:
  - Legal glyph: hex nibble = decoded value, blank[i]=0.
  - Blank: nibble=0, blank[i]=1.
  - Illegal: nibble unchanged, blank[i] unchanged, bad=1.
  - dvalid[i]=1 in every case.
- Latency: an input held constant from before edge 1 commits on edge STABLE+2, with outputs visible after that edge. Default: edge 6.
- frame = &dvalid, registered; it rises on the edge after the last dvalid sets.
- ack:
  - Clears dvalid, bad and frame on the next edge. hex and blank keep their values.
  - ack coincident with a commit: the commit wins for dvalid[i] and bad (set), and all other bits clear.
- A digit whose enable is rescanned with an identical pattern does not re-commit while the FSM stays in HOLD. Scanning to another digit and back re-commits with the same value, which is harmless.
- Reset mid-TRACK: the partial count is discarded and no commit occurs.

Optional Feature:
- SEG2HEX_DP_EN defined:
  - seg widens to 8 bits; bit7 = decimal point, active-low.
  - Adds output dp [DIGITS-1:0], set at commit to the inverted bit7.
  - bit7 takes part in the stability compare.
  - The decode table ignores bit7.
  - dp resets to 0.
- Undefined: seg is 7 bits and there is no dp port.

Test Plan:
- Reset check: with clrn low, all outputs are 0. Release, then apply an=11111110, seg=0110000 (3) -> edge 6: hex[3:0]=3, dvalid=00000001, blank=0, bad=0.
- Debounce: an=11111101, seg toggles between 0010010 and 0000010 every 2 cycles for 20 cycles -> no commit, dvalid[1]=0. Then hold 0000010 -> hex[7:4]=6 after STABLE+2 edges.
- Full scan: digits 0..7 get patterns for 1,2,..,8, each held 8 cycles -> hex=32'h87654321, frame=1 one edge after dvalid=8'hFF. Then ack -> dvalid=0, frame=0, hex unchanged.
- Illegal and blank: digit 2 held at 1111110 -> bad=1 and hex[11:8] keeps its prior value. Digit 3 held at 1111111 -> blank[3]=1, hex[15:12]=0.
- Bad enables: an=11111100 or 11111111 with any seg for 30 cycles -> no commits, FSM stays in IDLE.
- Reset mid-TRACK: clrn pulsed at cycle 3 of a digit-0 sequence -> no commit; after release a fresh STABLE+2 edges are needed.
